// File: rtl/m_drop_controller_pkg.sv
// Board geometry, field widths and FSM encoding shared by the drop controller
// and its pile counter.
package m_drop_controller_pkg;
   localparam int COL_COUNT             = 7;
   localparam int ROW_COUNT             = 6;
   localparam int COL_SIZE              = 3;
   localparam int ROW_SIZE              = 3;
   localparam int PILE_COUNT_ARRAY_SIZE = COL_COUNT * ROW_SIZE;
   localparam int MOVE_SIZE             = 6;
   localparam int CELL_COUNT            = COL_COUNT * ROW_COUNT;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EVAL = 2'd1,
      S_OUT  = 2'd2
   } state_t;
endpackage

// File: rtl/m_pile_counter.sv
// Looks up the stack height of one column and produces the array with that
// column bumped by one. Out-of-range columns report height 0.
module m_pile_counter
   import m_drop_controller_pkg::*;
(
   input  logic [PILE_COUNT_ARRAY_SIZE-1:0] i_pile_count_array,
   input  logic [COL_SIZE-1:0]              i_col,
   output logic                             o_valid,
   output logic [ROW_SIZE-1:0]              o_height,
   output logic [PILE_COUNT_ARRAY_SIZE-1:0] o_pile_count_array
);
   logic [ROW_SIZE-1:0] h;

   always_comb begin
      h                  = '0;
      o_pile_count_array = i_pile_count_array;
      for (int c = 0; c < COL_COUNT; c++) begin
         if (i_col == COL_SIZE'(c)) begin
            h = i_pile_count_array[c*ROW_SIZE +: ROW_SIZE];
            o_pile_count_array[c*ROW_SIZE +: ROW_SIZE] = h + ROW_SIZE'(1);
         end
      end
   end

   assign o_height = h;
   assign o_valid  = (h < ROW_SIZE'(ROW_COUNT));
endmodule

// File: rtl/m_drop_controller.sv
// Connect-Four move sequencer: accepts column drops, validates them against
// the pile-count array, and presents each committed drop until acknowledged.
module m_drop_controller
   import m_drop_controller_pkg::*;
(
   input  logic                             i_clk,
   input  logic                             i_rst_n,
   input  logic                             i_clear,
   input  logic                             i_req,
   input  logic [COL_SIZE-1:0]              i_col,
   output logic                             o_ready,
   output logic                             o_reject,
   output logic                             o_drop_valid,
   output logic [COL_SIZE-1:0]              o_drop_col,
   output logic [ROW_SIZE-1:0]              o_drop_row,
   output logic                             o_drop_player,
   input  logic                             i_drop_ack,
   output logic                             o_player,
   output logic [PILE_COUNT_ARRAY_SIZE-1:0] o_pile_count_array,
   output logic [MOVE_SIZE-1:0]             o_move_count,
   output logic                             o_board_full
);
   state_t                           state, nxt_state;
   logic [COL_SIZE-1:0]              r_col, nxt_col;
   logic [PILE_COUNT_ARRAY_SIZE-1:0] r_arr, nxt_arr;
   logic [MOVE_SIZE-1:0]             r_cnt, nxt_cnt;
   logic                             r_player, nxt_player;
   logic                             r_reject, nxt_reject;
   logic                             r_dv, nxt_dv;
   logic [COL_SIZE-1:0]              r_dcol, nxt_dcol;
   logic [ROW_SIZE-1:0]              r_drow, nxt_drow;
   logic                             r_dpl, nxt_dpl;

   logic                             pc_valid;
   logic [ROW_SIZE-1:0]              pc_height;
   logic [PILE_COUNT_ARRAY_SIZE-1:0] pc_arr;
   logic                             col_ok;

   m_pile_counter u_pile_counter (
      .i_pile_count_array (r_arr),
      .i_col              (r_col),
      .o_valid            (pc_valid),
      .o_height           (pc_height),
      .o_pile_count_array (pc_arr)
   );

   // The pile counter aliases column 7 onto nothing, so range-check here.
   assign col_ok       = (r_col < COL_SIZE'(COL_COUNT)) && pc_valid;
   assign o_board_full = (r_cnt == MOVE_SIZE'(CELL_COUNT));
   assign o_ready      = (state == S_IDLE) && !o_board_full;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= S_IDLE;
         r_col    <= '0;
         r_arr    <= '0;
         r_cnt    <= '0;
         r_player <= 1'b0;
         r_reject <= 1'b0;
         r_dv     <= 1'b0;
         r_dcol   <= '0;
         r_drow   <= '0;
         r_dpl    <= 1'b0;
      end else begin
         state    <= nxt_state;
         r_col    <= nxt_col;
         r_arr    <= nxt_arr;
         r_cnt    <= nxt_cnt;
         r_player <= nxt_player;
         r_reject <= nxt_reject;
         r_dv     <= nxt_dv;
         r_dcol   <= nxt_dcol;
         r_drow   <= nxt_drow;
         r_dpl    <= nxt_dpl;
      end
   end

   always_comb begin
      nxt_state  = state;
      nxt_col    = r_col;
      nxt_arr    = r_arr;
      nxt_cnt    = r_cnt;
      nxt_player = r_player;
      nxt_reject = 1'b0;
      nxt_dv     = r_dv;
      nxt_dcol   = r_dcol;
      nxt_drow   = r_drow;
      nxt_dpl    = r_dpl;
      if (i_clear) begin
         nxt_state  = S_IDLE;
         nxt_arr    = '0;
         nxt_cnt    = '0;
         nxt_player = 1'b0;
         nxt_dv     = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_req && o_ready) begin
                  nxt_col   = i_col;
                  nxt_state = S_EVAL;
               end
            end
            S_EVAL: begin
               if (col_ok) begin
                  nxt_arr   = pc_arr;
                  if (r_cnt < MOVE_SIZE'(CELL_COUNT))
                     nxt_cnt = r_cnt + MOVE_SIZE'(1);
                  nxt_dv    = 1'b1;
                  nxt_dcol  = r_col;
                  nxt_drow  = pc_height;
                  nxt_dpl   = r_player;
                  nxt_state = S_OUT;
               end else begin
                  nxt_reject = 1'b1;
                  nxt_state  = S_IDLE;
               end
            end
            S_OUT: begin
               if (i_drop_ack) begin
                  nxt_dv     = 1'b0;
                  nxt_player = ~r_player;
                  nxt_state  = S_IDLE;
               end
            end
            default: nxt_state = S_IDLE;
         endcase
      end
   end

   assign o_reject           = r_reject;
   assign o_drop_valid       = r_dv;
   assign o_drop_col         = r_dcol;
   assign o_drop_row         = r_drow;
   assign o_drop_player      = r_dpl;
   assign o_player           = r_player;
   assign o_pile_count_array = r_arr;
   assign o_move_count       = r_cnt;
endmodule

// File: doc/m_drop_controller.md
# m_drop_controller

Move sequencer for the Connect-Four board. It owns the registered pile-count array, which holds per-column stack heights. It accepts column-drop requests over a valid/ready handshake and uses `m_pile_counter` to validate each request and compute the landing row. It then presents each committed drop to the display/win-check side, holding it until that side acknowledges. It sits between the input front end (buttons/UART decode) and the renderer/judge, and it tracks whose turn it is and whether the board is full.

## Interface
- `COL_COUNT`, 7, columns (from `config.vh`)
- `ROW_COUNT`, 6, rows (from `config.vh`)
- `COL_SIZE`, 3, column index width
- `ROW_SIZE`, 3, row/height width
- `PILE_COUNT_ARRAY_SIZE`, 21, `COL_COUNT*ROW_SIZE`; column c occupies bits `[c*ROW_SIZE +: ROW_SIZE]`
- `MOVE_SIZE`, 6, move counter width (holds 0..42)

Ports:
- `i_clk`  in  1  system clock
- `i_rst_n`  in  1  reset; one clock; asynchronous, active-low
- `i_clear`  in  1  synchronous new-game request
- `i_req`  in  1  drop request valid
- `i_col`  in  COL_SIZE  requested column
- `o_ready`  out  1  controller can accept a request
- `o_reject`  out  1  one-cycle pulse: request refused
- `o_drop_valid`  out  1  committed drop presented
- `o_drop_col`  out  COL_SIZE  column of drop
- `o_drop_row`  out  ROW_SIZE  landing row, 0 = bottom
- `o_drop_player`  out  1  player who dropped (0/1)
- `i_drop_ack`  in  1  consumer accepted the drop
- `o_player`  out  1  player to move next
- `o_pile_count_array`  out  PILE_COUNT_ARRAY_SIZE  current heights
- `o_move_count`  out  MOVE_SIZE  pieces on board
- `o_board_full`  out  1  `o_move_count == COL_COUNT*ROW_COUNT`

## Operation
- FSM states:
  - `S_IDLE`: `o_ready = !o_board_full`. On `i_req && o_ready`, latch `i_col` into `r_col` and go to `S_EVAL`.
  - `S_EVAL`: `m_pile_counter` is driven combinationally from the array register and `r_col`.
    - Valid (`r_col < COL_COUNT` and height `< ROW_COUNT`): write the updated array, increment the move count, load the drop outputs (row = height before the drop, player = `o_player`), and go to `S_OUT`.
    - Invalid: pulse `o_reject` and return to `S_IDLE`. The array, turn and count are unchanged.
  - `S_OUT`: hold `o_drop_valid` and all drop fields stable until `i_drop_ack`. On ack, toggle `o_player` and go to `S_IDLE`.
- `o_ready` is low in `S_EVAL` and `S_OUT`. A request raised while not ready is ignored, not queued.
- `i_clear` has highest priority in every state. It zeroes the array and the move count, sets `o_player` to 0, drops `o_drop_valid`, and forces `S_IDLE`. An in-flight drop is discarded.
- Full board: `o_ready` is 0, no request is accepted, and no reject is issued. Only `i_clear` or reset leaves this condition.
- Width rules: the move count saturates logically at 42 and never wraps. Heights never exceed `ROW_COUNT`.

## Timing
- Reset values: state `S_IDLE`, array 0, `o_player` 0, `o_move_count` 0, `o_board_full` 0, `o_ready` 1, `o_reject` 0, `o_drop_valid` 0, `o_drop_col`/`o_drop_row`/`o_drop_player` 0.
- Request accepted at edge N → evaluated in cycle N+1 → at edge N+2 either `o_drop_valid` rises or `o_reject` pulses for exactly one cycle.
- The array and move-count update are visible from edge N+2, the same edge that raises `o_drop_valid`.
- `i_drop_ack` sampled at edge M with `o_drop_valid` high → `o_drop_valid` is 0 and `o_player` toggled from edge M+1.
- `o_ready` returns to 1 at edge M+1, so the minimum request-to-request spacing is 3 cycles when ack is immediate.
- `i_drop_ack` outside `S_OUT` is ignored.
- Reset mid-operation is asynchronous; all outputs reach reset values immediately.

## Structure
- `config.vh` holds `COL_COUNT`, `ROW_COUNT`, `COL_SIZE`, `ROW_SIZE`, `PILE_COUNT_ARRAY_SIZE` and state encodings (`S_IDLE`/`S_EVAL`/`S_OUT`, 2 bits).
- Sub-module: one existing `m_pile_counter` instance, fed by the array register and `r_col`. Its `o_valid` is combined with the `r_col < COL_COUNT` check.
- All state is registered in `m_drop_controller`, with no combinational path from `i_req` to the drop outputs.

## Test plan
- Reset, then request col 3 with immediate ack → drop `col=3 row=0 player=0`; array field 3 = 1; `o_player=1`; `o_move_count=1`.
- Seven requests to col 0 with ack each time:
  - First six → rows 0..5 with players alternating 0,1,0,1,0,1.
  - Seventh → `o_reject` pulses for one cycle; array, player and count unchanged.
- Request col 7 (out of range) → `o_reject` pulse, no state change; then request col 6 → accepted with row 0.
- Hold `i_drop_ack` low for 10 cycles → drop fields stable and `o_ready=0` throughout; `i_req` during the hold is ignored.
- Assert `i_clear` during `S_OUT` → next cycle `o_drop_valid=0`, array 0, `o_player=0`, count 0.
- Fill all 42 cells → `o_board_full=1` and `o_ready=0`; further `i_req` gives no reject; assert `i_rst_n` low mid-drop → all outputs at reset values.
